// File: rtl/rs_msg_deframer.sv
// rs_msg_deframer
// Sits behind the RS decoder. The decoder-input sync is re-timed by the decoder
// latency so that it lines up with symbol 0 of the corrected stream. The block
// then forwards the k message symbols with valid/sop/eop framing, drops the
// n-k parity symbols, and pulses frame_err when a new frame starts before the
// current one has run its full n symbols.
// Optional build macro: RS_STATS_EN adds saturating frame_cnt/trunc_cnt outputs.
module rs_msg_deframer #(
  parameter int n       = 255,
  parameter int k       = 239,
  parameter int m       = 8,
  parameter int LATENCY = 287
) (
  input  logic         clk_in,
  input  logic         sys_rst_n,
  input  logic         sync,
  input  logic [m-1:0] dec_data,
  output logic [m-1:0] msg_data,
  output logic         msg_valid,
  output logic         msg_sop,
  output logic         msg_eop,
  output logic         frame_err
`ifdef RS_STATS_EN
  ,
  output logic [15:0]  frame_cnt,
  output logic [15:0]  trunc_cnt
`endif
);

  localparam int CNT_W = (n > 1) ? $clog2(n) : 1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(k - 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(n - 1);

  typedef enum logic [1:0] {IDLE, MSG, PARITY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   sym_cnt;
  logic               sync_q;
  logic               start_in;
  logic               start_d;
  // Holds the inverted start pulse so that the all-ones reset value reads as
  // "no start in flight", matching an inactive (high) sync.
  logic [LATENCY-1:0] start_n_dly;

  assign start_in = sync_q & ~sync;
  assign start_d  = ~start_n_dly[LATENCY-1];

  // Edge-detect sync and carry the start pulse across the decoder latency.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q      <= 1'b1;
      start_n_dly <= '1;
    end else begin
      sync_q         <= sync;
      start_n_dly[0] <= ~start_in;
      for (int i = 1; i < LATENCY; i++) start_n_dly[i] <= start_n_dly[i-1];
    end
  end

  // Frame FSM: tracks symbol index and drives the registered message outputs.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      sym_cnt   <= '0;
      msg_data  <= '0;
      msg_valid <= 1'b0;
      msg_sop   <= 1'b0;
      msg_eop   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      msg_sop   <= 1'b0;
      msg_eop   <= 1'b0;
      frame_err <= 1'b0;
      if (start_d) begin
        // Outside IDLE the index is always 1..n-1, so any start there truncates.
        frame_err <= (state != IDLE);
        msg_data  <= dec_data;
        msg_valid <= 1'b1;
        msg_sop   <= 1'b1;
        msg_eop   <= (k == 1);
        state     <= (k == 1) ? PARITY : MSG;
        sym_cnt   <= CNT_W'(1);
      end else begin
        case (state)
          MSG: begin
            msg_data  <= dec_data;
            msg_valid <= 1'b1;
            sym_cnt   <= sym_cnt + 1'b1;
            if (sym_cnt == K_LAST) begin
              msg_eop <= 1'b1;
              state   <= PARITY;
            end
          end
          PARITY: begin
            if (sym_cnt == N_LAST) begin
              state   <= IDLE;
              sym_cnt <= '0;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RS_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Completed and truncated frame statistics, saturating.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      if (start_d && state != IDLE)
        trunc_cnt <= sat_inc(trunc_cnt);
      if (!start_d && state == PARITY && sym_cnt == N_LAST)
        frame_cnt <= sat_inc(frame_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rs_msg_deframer.sv
// Bench for rs_msg_deframer: a full-size instance driven with directed sync
// scenarios and random data, plus a tiny n=7,k=1,LATENCY=3 instance driven with
// random sync. Expected outputs come from a frame-position model built on start
// times and symbol indices.
module tb_rs_msg_deframer;

  localparam int MAXC = 12000;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       sync_a = 1'b1, sync_b = 1'b1;
  logic [7:0] data_a = '0, data_b = '0;
  logic [7:0] md_a, md_b;
  logic       v_a, sop_a, eop_a, err_a;
  logic       v_b, sop_b, eop_b, err_b;
`ifdef RS_STATS_EN
  logic [15:0] fc_a, tc_a, fc_b, tc_b;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rst_cyc = 0;

  bit         hist [2][MAXC];
  bit         prev_s [2];
  bit         has_s [2];
  int         last_s [2];
  logic [7:0] hold [2];
  int         frames [2];
  int         truncs [2];

  always #5 clk = ~clk;

  rs_msg_deframer #(.n(255), .k(239), .m(8), .LATENCY(287)) dut_a (
    .clk_in(clk), .sys_rst_n(sys_rst_n), .sync(sync_a), .dec_data(data_a),
    .msg_data(md_a), .msg_valid(v_a), .msg_sop(sop_a), .msg_eop(eop_a),
    .frame_err(err_a)
`ifdef RS_STATS_EN
    , .frame_cnt(fc_a), .trunc_cnt(tc_a)
`endif
  );

  rs_msg_deframer #(.n(7), .k(1), .m(8), .LATENCY(3)) dut_b (
    .clk_in(clk), .sys_rst_n(sys_rst_n), .sync(sync_b), .dec_data(data_b),
    .msg_data(md_b), .msg_valid(v_b), .msg_sop(sop_b), .msg_eop(eop_b),
    .frame_err(err_b)
`ifdef RS_STATS_EN
    , .frame_cnt(fc_b), .trunc_cnt(tc_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      prev_s[i] = 1'b1;
      has_s[i]  = 1'b0;
      last_s[i] = 0;
      hold[i]   = '0;
      frames[i] = 0;
      truncs[i] = 0;
    end
    rst_cyc = cyc;
  endtask

  // Expected {valid,sop,eop,err,data} seen after the edge that ends cycle cyc.
  task automatic model_step(input int i, input int nn, input int kk, input int ll,
                            input bit s, input logic [7:0] d, output logic [11:0] e);
    bit v, sp, ep, er, due;
    int idx;
    v = 0; sp = 0; ep = 0; er = 0; due = 0;
    hist[i][cyc] = prev_s[i] & ~s;
    prev_s[i] = s;
    if (cyc - ll >= rst_cyc) due = hist[i][cyc-ll];
    idx = cyc - last_s[i];
    if (due) begin
      if (has_s[i] && idx >= 1 && idx <= nn-1) begin
        er = 1;
        if (truncs[i] < 65535) truncs[i]++;
      end
      has_s[i] = 1; last_s[i] = cyc;
      v = 1; sp = 1; ep = (kk == 1); hold[i] = d;
    end else if (has_s[i] && idx >= 1 && idx <= kk-1) begin
      v = 1; ep = (idx == kk-1); hold[i] = d;
    end else if (has_s[i] && idx == nn-1) begin
      if (frames[i] < 65535) frames[i]++;
    end
    e = {v, sp, ep, er, hold[i]};
  endtask

  task automatic tick(input bit sa);
    logic [11:0] ea, eb;
    bit sb;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    sb = ($urandom_range(0, 3) != 0);
    sync_a = sa; sync_b = sb;
    data_a = 8'($urandom); data_b = 8'($urandom);
    model_step(0, 255, 239, 287, sa, data_a, ea);
    model_step(1, 7, 1, 3, sb, data_b, eb);
    cyc++;
    @(posedge clk); #1;
    check("a_out", {20'd0, v_a, sop_a, eop_a, err_a, md_a}, {20'd0, ea});
    check("b_out", {20'd0, v_b, sop_b, eop_b, err_b, md_b}, {20'd0, eb});
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) tick(1'b1);
  endtask

  task automatic do_reset();
    sync_a = 1'b1; sync_b = 1'b1;
    sys_rst_n = 1'b0;
    #1;
    check("rst_a", {20'd0, v_a, sop_a, eop_a, err_a, md_a}, 32'd0);
    check("rst_b", {20'd0, v_b, sop_b, eop_b, err_b, md_b}, 32'd0);
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    // Single frame.
    tick(1'b0); idle(600);
    // Back-to-back frames.
    tick(1'b0); idle(254); tick(1'b0); idle(600);
    // Truncation after 100 symbols.
    tick(1'b0); idle(99); tick(1'b0); idle(600);
    // Sync held low for a long time.
    repeat (600) tick(1'b0);
    idle(600);
    // Reset mid-frame, then silence.
    tick(1'b0); idle(399);
    do_reset();
    idle(400);
    // Random start spacing, including truncations and back-to-back.
    for (int j = 0; j < 8; j++) begin
      tick(1'b0);
      idle($urandom_range(20, 400));
    end
    idle(600);
`ifdef RS_STATS_EN
    check("a_frame_cnt", {16'd0, fc_a}, 32'(frames[0]));
    check("a_trunc_cnt", {16'd0, tc_a}, 32'(truncs[0]));
    check("b_frame_cnt", {16'd0, fc_b}, 32'(frames[1]));
    check("b_trunc_cnt", {16'd0, tc_b}, 32'(truncs[1]));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
